// File: rtl/keypad_scanner.sv
// Scans a 4x4 active-low keypad, debounces press and release, and emits one
// registered key code plus a single-cycle strobe per physical press.
package calc_pkg;
  typedef enum logic [3:0] {
    B_NUM_0, B_NUM_1, B_NUM_2, B_NUM_3, B_NUM_4,
    B_NUM_5, B_NUM_6, B_NUM_7, B_NUM_8, B_NUM_9,
    B_ADD, B_SUB, B_MUL, B_DIV, B_EQ, B_DOT
  } active_button_t;
endpackage

module keypad_scanner #(
  parameter int SettleCycles   = 4,
  parameter int DebounceCycles = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  output logic [3:0]               row_o,
  input  logic [3:0]               col_i,
  output calc_pkg::active_button_t active_button_o,
  output logic                     new_input_o
);
  import calc_pkg::*;

  localparam int CntMax = (SettleCycles > DebounceCycles) ? SettleCycles : DebounceCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] DebLast    = CntW'(DebounceCycles - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        row_q, row_d;
  logic [CntW-1:0]   settle_cnt, settle_d;
  logic [CntW-1:0]   deb_cnt, deb_d;
  logic [3:0]        col_q, col_d;
  logic [3:0]        col_meta, col_s;
  logic              one_low;
  logic              accept;
  active_button_t    button_d;

  function automatic active_button_t key_map(input logic [1:0] r, input logic [3:0] c);
    logic [1:0] ci;
    active_button_t b;
    case (c)
      4'b1110: ci = 2'd0;
      4'b1101: ci = 2'd1;
      4'b1011: ci = 2'd2;
      default: ci = 2'd3;
    endcase
    case ({r, ci})
      4'h0: b = B_NUM_1;  4'h1: b = B_NUM_2;  4'h2: b = B_NUM_3;  4'h3: b = B_ADD;
      4'h4: b = B_NUM_4;  4'h5: b = B_NUM_5;  4'h6: b = B_NUM_6;  4'h7: b = B_SUB;
      4'h8: b = B_NUM_7;  4'h9: b = B_NUM_8;  4'hA: b = B_NUM_9;  4'hB: b = B_MUL;
      4'hC: b = B_DOT;    4'hD: b = B_NUM_0;  4'hE: b = B_EQ;     default: b = B_DIV;
    endcase
    return b;
  endfunction

  // Two or more low columns is a ghost / multi-key and is skipped like no key.
  assign one_low = col_s inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= SCAN;
      row_q           <= 2'd0;
      row_o           <= 4'b1110;
      settle_cnt      <= '0;
      deb_cnt         <= '0;
      col_q           <= 4'hF;
      col_meta        <= 4'hF;
      col_s           <= 4'hF;
      active_button_o <= B_NUM_0;
      new_input_o     <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      row_o       <= ~(4'b0001 << row_d);
      settle_cnt  <= settle_d;
      deb_cnt     <= deb_d;
      col_q       <= col_d;
      col_meta    <= col_i;
      col_s       <= col_meta;
      new_input_o <= accept;
      if (accept) active_button_o <= button_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    settle_d = settle_cnt;
    deb_d    = deb_cnt;
    col_d    = col_q;
    case (state_q)
      SCAN: begin
        if (settle_cnt == SettleLast) begin
          if (one_low) begin
            col_d   = col_s;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            row_d    = row_q + 2'd1;
            settle_d = '0;
          end
        end else begin
          settle_d = settle_cnt + CntW'(1);
        end
      end
      DEBOUNCE: begin
        if (col_s != col_q) begin
          state_d  = SCAN;
          row_d    = row_q + 2'd1;
          settle_d = '0;
        end else if (accept) begin
          state_d = RELEASE;
          deb_d   = '0;
        end else begin
          deb_d = deb_cnt + CntW'(1);
        end
      end
      RELEASE: begin
        if (col_s != 4'hF) begin
          deb_d = '0;
        end else if (deb_cnt == DebLast) begin
          state_d  = SCAN;
          row_d    = row_q + 2'd1;
          settle_d = '0;
        end else begin
          deb_d = deb_cnt + CntW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_comb begin
    accept   = (state_q == DEBOUNCE) && (col_s == col_q) && (deb_cnt == DebLast);
    button_d = key_map(row_q, col_q);
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// Drives a modelled key matrix and checks strobes against expected key codes
// and timing windows derived from the scan/debounce rules.
module tb_keypad_scanner;
  import calc_pkg::*;

  localparam int S = 4;
  localparam int D = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [3:0]     row_o;
  logic [3:0]     col_i;
  active_button_t btn;
  logic           new_input;
  logic [15:0]    down = '0;

  keypad_scanner #(.SettleCycles(S), .DebounceCycles(D)) dut (
    .clk_i(clk), .rst_i(rst), .row_o(row_o), .col_i(col_i),
    .active_button_o(btn), .new_input_o(new_input)
  );

  // Physical matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    col_i = 4'hF;
    for (int k = 0; k < 16; k++)
      if (down[k] && (row_o[k/4] == 1'b0)) col_i[k%4] = 1'b0;
  end

  active_button_t keymap [16] = '{
    B_NUM_1, B_NUM_2, B_NUM_3, B_ADD,
    B_NUM_4, B_NUM_5, B_NUM_6, B_SUB,
    B_NUM_7, B_NUM_8, B_NUM_9, B_MUL,
    B_DOT,   B_NUM_0, B_EQ,    B_DIV
  };

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int pulse_cyc[$];
  active_button_t pulse_val[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Observer: records every strobe and checks scan/strobe invariants.
  initial begin
    logic prev;
    int   last;
    prev = 1'b0;
    last = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
        last = -1;
      end else begin
        check("row_one_low", $countones(~row_o), 1);
        if (new_input) begin
          check("no_back_to_back", int'(prev), 0);
          if (last >= 0) check("strobe_spacing", int'(cyc - last >= 2*D + S), 1);
          last = cyc;
          pulse_cyc.push_back(cyc);
          pulse_val.push_back(btn);
        end
        prev = new_input;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    c0 = cyc;
  endtask

  // One press episode: optional press bounce, stable hold, optional release
  // re-contacts, long open gap. Segment length 0 means random.
  task automatic run_episode(input string tag, input int key, input int nb, input int bseg,
                             input int nrc, input int rseg);
    int n0, s, p, hold;
    n0 = pulse_cyc.size();
    for (int b = 0; b < nb; b++) begin
      down[key] = 1'b1;
      tick(bseg > 0 ? bseg : $urandom_range(1, 6));
      down[key] = 1'b0;
      tick(bseg > 0 ? bseg : $urandom_range(3, 6));
    end
    down[key] = 1'b1;
    s = cyc;
    hold = 60 + $urandom_range(0, 40);
    tick(hold);
    down[key] = 1'b0;
    for (int r = 0; r < nrc; r++) begin
      tick(rseg > 0 ? 2*rseg : $urandom_range(1, 4));
      down[key] = 1'b1;
      tick(rseg > 0 ? rseg : $urandom_range(1, 3));
      down[key] = 1'b0;
    end
    tick(D + 10 + $urandom_range(0, 10));
    check({tag, "_count"}, pulse_cyc.size() - n0, 1);
    if (pulse_cyc.size() > n0) begin
      p = pulse_cyc[n0];
      check({tag, "_value"}, int'(pulse_val[n0]), int'(keymap[key]));
      check({tag, "_lat_min"}, int'(p >= s + D + 3), 1);
      check({tag, "_lat_max"}, int'(p <= s + 2 + 4*S + D + 1), 1);
    end
  endtask

  initial begin
    int n0, rel;
    logic [3:0] exp_row;

    // Reset state
    do_reset();
    check("rst_row", int'(row_o), 4'b1110);
    check("rst_button", int'(btn), int'(B_NUM_0));
    check("rst_strobe", int'(new_input), 0);
    tick(40);

    // Key 5 (r1c1) held from reset: one strobe, none while held
    down[5] = 1'b1;
    n0 = pulse_cyc.size();
    do_reset();
    wait_to(c0 + 200);
    check("k5_count", pulse_cyc.size() - n0, 1);
    if (pulse_cyc.size() > n0) begin
      check("k5_cycle", pulse_cyc[n0] - c0, 24);
      check("k5_value", int'(pulse_val[n0]), int'(B_NUM_5));
    end
    down[5] = 1'b0;
    tick(40);

    // Key 1 (r0c0) held through reset: strobe in cycle 20, row 0 held until release+16
    down[0] = 1'b1;
    n0 = pulse_cyc.size();
    do_reset();
    wait_to(c0 + 60);
    check("k1_row_held", int'(row_o), 4'b1110);
    check("k1_count", pulse_cyc.size() - n0, 1);
    if (pulse_cyc.size() > n0) begin
      check("k1_cycle", pulse_cyc[n0] - c0, 20);
      check("k1_value", int'(pulse_val[n0]), int'(B_NUM_1));
    end
    wait_to(c0 + 120);
    down[0] = 1'b0;
    rel = cyc;
    wait_to(rel + 17);
    check("k1_row_before_rel", int'(row_o), 4'b1110);
    wait_to(rel + 18);
    check("k1_row_after_rel", int'(row_o), 4'b1101);
    tick(40);

    // Ghost: r2c0 + r2c1 never accepted, scan keeps rotating every S cycles
    down[8] = 1'b1;
    down[9] = 1'b1;
    n0 = pulse_cyc.size();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      wait_to(c0 + k);
      exp_row = ~(4'b0001 << ((k / S) % 4));
      check("ghost_row", int'(row_o), int'(exp_row));
    end
    wait_to(c0 + 200);
    check("ghost_count", pulse_cyc.size() - n0, 0);
    down = '0;
    tick(40);

    // '=' with 40 cycles of 5-cycle bounce, then held
    run_episode("eq_bounce", 14, 4, 5, 0, 0);
    // '+' with three release re-contacts, then '-'
    run_episode("add_relbounce", 3, 0, 0, 3, 1);
    run_episode("sub_after", 7, 0, 0, 0, 0);

    // Reset mid-debounce on key 5 at deb_cnt == 10
    down[5] = 1'b1;
    n0 = pulse_cyc.size();
    do_reset();
    wait_to(c0 + 18);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("midrst_row", int'(row_o), 4'b1110);
    check("midrst_button", int'(btn), int'(B_NUM_0));
    check("midrst_strobe", int'(new_input), 0);
    down[5] = 1'b0;
    tick(40);
    check("midrst_count", pulse_cyc.size() - n0, 0);

    // Randomized press episodes
    for (int e = 0; e < 12; e++)
      run_episode("rand", $urandom_range(0, 15), $urandom_range(0, 3), 0,
                  $urandom_range(0, 3), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces presses and releases, and produces the `calc_pkg::active_button_t` code plus a one-cycle `new_input` strobe consumed by the calculator `controller`. It sits between the board keypad pins and the controller's `active_button_i` / `new_input_i` inputs. It emits exactly one strobe per physical press, with no auto-repeat.

## Interface
- `SettleCycles`, default 4: cycles each row is driven before its columns are sampled. Must be ≥ 3 to cover the 2-flop synchronizer.
- `DebounceCycles`, default 16: consecutive stable samples required to accept a press or a release. Use ~1_000_000 on hardware.
- `clk_i` in 1: system clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `row_o` out 4: row drive, active-low, exactly one bit low at all times.
- `col_i` in 4: column sense, active-low with external pull-ups, asynchronous.
- `active_button_o` out `calc_pkg::active_button_t`: code of the last accepted key. Held until the next accepted key.
- `new_input_o` out 1: one-cycle pulse when a new key is accepted.

## Operation
- `col_i` passes through a 2-flop synchronizer. All decisions use the synchronized value `col_s`.
- Key map, row r / col c:
  - r0: B_NUM_1, B_NUM_2, B_NUM_3, B_ADD
  - r1: B_NUM_4, B_NUM_5, B_NUM_6, B_SUB
  - r2: B_NUM_7, B_NUM_8, B_NUM_9, B_MUL
  - r3: B_DOT, B_NUM_0, B_EQ, B_DIV
- Row index `row_q` (2 bits) drives `row_o = ~(4'b1 << row_q)`. It wraps 3→0.
- **SCAN**
  - `settle_cnt` counts 0..SettleCycles-1 while `row_q` is held.
  - At `settle_cnt == SettleCycles-1`, sample `col_s`:
    - exactly one bit low → latch `col_q`, clear `deb_cnt`, go to DEBOUNCE with `row_q` held;
    - otherwise (none low, or 2+ low = ghost/multi-key) → `row_q++`, `settle_cnt = 0`.
- **DEBOUNCE**
  - Each cycle `col_s == col_q`: `deb_cnt++`.
  - Any mismatch → SCAN, `row_q++`, `settle_cnt = 0`, no strobe.
  - At `deb_cnt == DebounceCycles-1` with a match → register `active_button_o = map(row_q, col_q)`, pulse `new_input_o`, go to RELEASE.
- **RELEASE**
  - `row_q` is held.
  - `col_s == 4'hF` → `deb_cnt++`; any low bit → `deb_cnt = 0`.
  - At `deb_cnt == DebounceCycles-1` with all high → SCAN, `row_q++`, `settle_cnt = 0`.
  - Keys pressed on other rows during RELEASE are not seen.
- Counter widths are `$clog2(max(SettleCycles, DebounceCycles)+1)`. Counters saturate-free; they are cleared on every state entry.

## Timing
- Reset values:
  - state = SCAN, `row_q` = 0 so `row_o` = 4'b1110;
  - `settle_cnt` = `deb_cnt` = 0; synchronizer flops = 4'hF;
  - `active_button_o` = B_NUM_0; `new_input_o` = 0.
- All outputs are registered. `new_input_o` and the new `active_button_o` are valid in the same cycle, one cycle after the final matching DEBOUNCE sample.
- `new_input_o` is never high on two consecutive cycles. The minimum spacing between strobes is 2·DebounceCycles + SettleCycles cycles.
- Worst-case press latency from stable `col_i`: 2 + 4·SettleCycles + DebounceCycles + 1 cycles.
- `rst_i` asserted mid-DEBOUNCE or mid-RELEASE aborts with no strobe. The first cycle after release from reset is in SCAN on row 0.
- A bounce in the last DEBOUNCE cycle produces no strobe.
- A key held across reset is detected again after reset. This is intended.

## Test plan
- Key r1c1 (`5`) held: from reset, `col_i` = 4'b1101 only while `row_o` = 4'b1101 → exactly one `new_input_o` pulse with `active_button_o` = B_NUM_5. No second pulse while held for 200 cycles.
- Key r0c0 (`1`) held through reset (cycle 0 = first cycle with `rst_i` low) → single pulse in cycle 20, `active_button_o` = B_NUM_1. `row_o` stays 4'b1110 until release + 16 cycles.
- Bounce: press `=` (r3c2), toggle the column every 5 cycles for 40 cycles, then hold → exactly one pulse, value B_EQ, only after 16 stable cycles.
- Ghost: r2 columns 0 and 1 both low → no pulse ever. Scan continues, and `row_o` cycles 1110→1101→1011→0111→1110 every 4 cycles.
- Release bounce: after accepting `+`, release with 3 re-contacts inside 10 cycles → no extra pulse. Next press `-` → pulse with B_SUB.
- Reset mid-DEBOUNCE: assert `rst_i` for 1 cycle at `deb_cnt` = 10 → no pulse, `row_o` = 4'b1110, `active_button_o` = B_NUM_0 next cycle.
